pipe_ctrl_regs: RTL

Execute/memory/writeback control-and-register-tag pipeline for the 5-stage MIPS core. It captures decoded D-stage control and register fields, applies the hazard unit's `flushE` bubble, and delivers exactly the E/M/W tags the hazard unit consumes: `rsE`, `rtE`, `writeregE/M/W`, `regwriteE/M/W` and `memtoregE/M`. It also keeps saturating performance counters for stall cycles, flushes and retired instructions.

---
 rtl/pipe_ctrl_regs_pkg.sv | 15 +
 rtl/pipe_ctrl_regs_sat_counter.sv | 20 ++
 rtl/pipe_ctrl_regs.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_regs_pkg.sv
// Shared types for the MIPS E/M/W control-and-tag pipeline.
package mips_pipe_pkg;

  typedef logic [4:0] regaddr_t;

  localparam regaddr_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memtoreg;
    logic memwrite;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_regs_sat_counter.sv
// Unsigned counter that saturates at all-ones; clear/reset win over increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl_regs.sv
// E/M/W control and register-tag pipeline feeding the hazard unit,
// with saturating stall/flush/retire performance counters.
module pipe_ctrl_regs
  import mips_pipe_pkg::*;
#(
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            validD,
  input  logic [4:0]      rsD,
  input  logic [4:0]      rtD,
  input  logic [4:0]      rdD,
  input  logic            regwriteD,
  input  logic            memtoregD,
  input  logic            memwriteD,
  input  logic            regdstD,
  input  logic            stallD,
  input  logic            flushE,
  input  logic            clr_cnt,
  output logic [4:0]      rsE,
  output logic [4:0]      rtE,
  output logic [4:0]      writeregE,
  output logic            regwriteE,
  output logic            memtoregE,
  output logic            validE,
  output logic [4:0]      writeregM,
  output logic            regwriteM,
  output logic            memtoregM,
  output logic            memwriteM,
  output logic            validM,
  output logic [4:0]      writeregW,
  output logic            regwriteW,
  output logic            memtoregW,
  output logic            validW,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt,
  output logic [CNTW-1:0] retire_cnt
);

  regaddr_t destD;
  regaddr_t rsEReg, rtEReg, wrEReg, wrMReg, wrWReg;
  ctrl_t    ctrlE, ctrlM, ctrlW;

  always_comb begin
    destD = regdstD ? rdD : rtD;
  end

  // Controls are gated by validD, and $zero writes are squashed here so no
  // later stage ever advertises a write to register 0.
  always_ff @(posedge clk) begin
    if (reset || flushE) begin
      rsEReg <= REG_ZERO;
      rtEReg <= REG_ZERO;
      wrEReg <= REG_ZERO;
      ctrlE  <= '0;
    end else begin
      rsEReg         <= rsD;
      rtEReg         <= rtD;
      wrEReg         <= destD;
      ctrlE.valid    <= validD;
      ctrlE.regwrite <= regwriteD && validD && (destD != REG_ZERO);
      ctrlE.memtoreg <= memtoregD && validD;
      ctrlE.memwrite <= memwriteD && validD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrMReg <= REG_ZERO;
      ctrlM  <= '0;
    end else begin
      wrMReg <= wrEReg;
      ctrlM  <= ctrlE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrWReg <= REG_ZERO;
      ctrlW  <= '0;
    end else begin
      wrWReg <= wrMReg;
      ctrlW  <= ctrlM;
    end
  end

  assign rsE       = rsEReg;
  assign rtE       = rtEReg;
  assign writeregE = wrEReg;
  assign regwriteE = ctrlE.regwrite;
  assign memtoregE = ctrlE.memtoreg;
  assign validE    = ctrlE.valid;
  assign writeregM = wrMReg;
  assign regwriteM = ctrlM.regwrite;
  assign memtoregM = ctrlM.memtoreg;
  assign memwriteM = ctrlM.memwrite;
  assign validM    = ctrlM.valid;
  assign writeregW = wrWReg;
  assign regwriteW = ctrlW.regwrite;
  assign memtoregW = ctrlW.memtoreg;
  assign validW    = ctrlW.valid;

  logic flushInc;
  assign flushInc = flushE && !stallD;

  // Load-use bubbles (flush with stall) are counted as stalls only.
  sat_counter #(.W(CNTW)) uStallCnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (stallD),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNTW)) uFlushCnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (flushInc),
    .count (flush_cnt)
  );

  sat_counter #(.W(CNTW)) uRetireCnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (ctrlW.valid),
    .count (retire_cnt)
  );

endmodule
